// File: rtl/charmquark1984_axis_scheduler.sv
// charmquark1984_axis_scheduler
//   Four-axis (x,y,z,e) step sequencer. Move commands arrive over a
//   valid/ready handshake. A shared prescaler produces step ticks, and a
//   round-robin arbiter hands each tick to one busy axis. The granted axis
//   advances its 2-bit Gray phase by one step in its commanded direction.
//
//   phase_out pin map: x=[1:0], y=[3:2], z=[5:4], e=[7:6].
//
//   Optional build macro: CONTROLLER_ABORT_EN
//     Adds a synchronous active-high 'abort' input. Abort discards every
//     pending move, keeps the phases where they are, emits no done pulses
//     and blocks command acceptance in that cycle.

module charmquark1984_axis_scheduler #(
    parameter int MAX_COUNT = 1000,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
`ifdef CONTROLLER_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_axis,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    output logic [7:0]       phase_out,
    output logic [3:0]       axis_busy,
    output logic [3:0]       done,
    output logic             tick
);

    localparam int               PRE_W    = (MAX_COUNT < 2) ? 1 : $clog2(MAX_COUNT + 1);
    localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);

    // The prescaler counts down from MAX_COUNT to zero. This gives the same tick
    // timing as counting up from zero to MAX_COUNT.
    logic [PRE_W-1:0] presc_q;
    logic             tick_q;

    // round-robin pointer: the axis that was granted last
    logic [1:0]       rr_q;

    logic [1:0]       phase_q [4];
    logic [CNT_W-1:0] rem_q   [4];
    logic [3:0]       dir_q;
    logic [3:0]       busy_q;
    logic [3:0]       done_q;

    logic             abort_i;
    logic             accept;
    logic             grant_vld;
    logic [1:0]       grant_axis;
    logic             step_en;

`ifdef CONTROLLER_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // One Gray step: forward is 00->01->11->10->00, and reverse is the opposite order.
    function automatic logic [1:0] gray_step(input logic [1:0] ph, input logic fwd);
        logic [1:0] nxt;
        nxt = ph;
        if (fwd) begin
            case (ph)
                2'b00:   nxt = 2'b01;
                2'b01:   nxt = 2'b11;
                2'b11:   nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end else begin
            case (ph)
                2'b00:   nxt = 2'b10;
                2'b10:   nxt = 2'b11;
                2'b11:   nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

    // A command is accepted only when its target axis is idle. Abort also blocks acceptance.
    assign cmd_ready = ~busy_q[cmd_axis] & ~abort_i;
    assign accept    = cmd_valid & cmd_ready;

    // Search rr+1, rr+2, rr+3 and then rr itself, using the registered busy flags.
    // The 2-bit sum wraps modulo 4. An offset of 4 therefore selects rr.
    always_comb begin
        grant_vld  = 1'b0;
        grant_axis = rr_q;
        for (int i = 1; i <= 4; i++) begin
            if (!grant_vld && busy_q[2'(rr_q + 2'(i))]) begin
                grant_vld  = 1'b1;
                grant_axis = 2'(rr_q + 2'(i));
            end
        end
    end

    assign step_en = tick_q & grant_vld & ~abort_i;

    // Prescaler: when the count reaches its terminal value, reload it and register a one-cycle tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= PRE_LOAD;
            tick_q  <= 1'b0;
        end else if (presc_q == '0) begin
            presc_q <= PRE_LOAD;
            tick_q  <= 1'b1;
        end else begin
            presc_q <= presc_q - PRE_W'(1);
            tick_q  <= 1'b0;
        end
    end

    // Round-robin pointer: move it to the granted axis. Hold it when no axis is stepped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q <= 2'd3;
        end else if (step_en) begin
            rr_q <= grant_axis;
        end
    end

    // Per-axis move state: abort clears first, then the granted step, then command load.
    // The granted axis is always busy, so it cannot also accept a command in that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int a = 0; a < 4; a++) begin
                phase_q[a] <= 2'b00;
                rem_q[a]   <= '0;
            end
            dir_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else begin
            done_q <= '0;
            for (int a = 0; a < 4; a++) begin
                if (abort_i) begin
                    rem_q[a]  <= '0;
                    busy_q[a] <= 1'b0;
                end else if (step_en && grant_axis == 2'(a)) begin
                    phase_q[a] <= gray_step(phase_q[a], dir_q[a]);
                    rem_q[a]   <= rem_q[a] - REM_ONE;
                    if (rem_q[a] == REM_ONE) begin
                        busy_q[a] <= 1'b0;
                        done_q[a] <= 1'b1;
                    end
                end else if (accept && cmd_axis == 2'(a)) begin
                    rem_q[a]  <= cmd_steps;
                    dir_q[a]  <= cmd_dir;
                    busy_q[a] <= |cmd_steps;
                    done_q[a] <= ~|cmd_steps;
                end
            end
        end
    end

    assign phase_out = {phase_q[3], phase_q[2], phase_q[1], phase_q[0]};
    assign axis_busy = busy_q;
    assign done      = done_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_charmquark1984_axis_scheduler.sv
// Testbench for charmquark1984_axis_scheduler (MAX_COUNT=3, CNT_W=8).
// The bench runs directed scenarios. It then runs a randomized run that is
// checked against a behavioural model. The model keeps, for each axis, a step
// position and a remaining count.

module tb_charmquark1984_axis_scheduler;

    localparam int MAX_COUNT = 3;
    localparam int CNT_W     = 8;
    localparam int PERIOD    = MAX_COUNT + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_axis = 2'd0;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_steps = '0;
    logic [7:0]       phase_out;
    logic [3:0]       axis_busy;
    logic [3:0]       done;
    logic             tick;
`ifdef CONTROLLER_ABORT_EN
    logic             abort = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int         m_pos  [4];
    int         m_rem  [4];
    bit         m_dir  [4];
    int         m_rr;
    int         m_edges;
    bit         m_tick;
    logic [3:0] m_done;
    logic [1:0] gray_tab [4];

    charmquark1984_axis_scheduler #(
        .MAX_COUNT(MAX_COUNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef CONTROLLER_ABORT_EN
        .abort    (abort),
`endif
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_axis (cmd_axis),
        .cmd_dir  (cmd_dir),
        .cmd_steps(cmd_steps),
        .phase_out(phase_out),
        .axis_busy(axis_busy),
        .done     (done),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] m_phase();
        logic [7:0] p;
        p = '0;
        for (int a = 0; a < 4; a++) p[2*a +: 2] = gray_tab[m_pos[a]];
        return p;
    endfunction

    function automatic logic [3:0] m_busy();
        logic [3:0] b;
        b = '0;
        for (int a = 0; a < 4; a++) b[a] = (m_rem[a] != 0);
        return b;
    endfunction

    task automatic do_reset();
        reset     = 1'b0;
        cmd_valid = 1'b0;
`ifdef CONTROLLER_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            m_pos[a] = 0;
            m_rem[a] = 0;
            m_dir[a] = 1'b0;
        end
        m_rr    = 3;
        m_edges = 0;
        m_tick  = 1'b0;
        m_done  = '0;
    endtask

    task automatic send(input logic [1:0] ax, input logic d, input logic [CNT_W-1:0] st);
        cmd_axis  = ax;
        cmd_dir   = d;
        cmd_steps = st;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) until tick is high, then advance one edge so the grant is visible.
    task automatic tick_step();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 4 * PERIOD) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_wait: tick=%b after %0d cycles, need 1", tick, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (phase_out !== 8'h00) begin errors++; $display("FAIL reset_phase: got %h need 00", phase_out); end
        checks++; if (axis_busy !== 4'h0)  begin errors++; $display("FAIL reset_busy: got %b need 0000", axis_busy); end
        checks++; if (done !== 4'h0)       begin errors++; $display("FAIL reset_done: got %b need 0000", done); end
        checks++; if (tick !== 1'b0)       begin errors++; $display("FAIL reset_tick: got %b need 0", tick); end
        checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b need 1", cmd_ready); end
    endtask

    task automatic test_single_fwd();
        logic [1:0] seq [4];
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        send(2'd0, 1'b1, 8'd4);
        checks++; if (axis_busy !== 4'b0001) begin errors++; $display("FAIL fwd_busy: got %b need 0001", axis_busy); end
        for (int k = 0; k < 4; k++) begin
            tick_step();
            checks++;
            if (phase_out !== {6'b0, seq[k]}) begin
                errors++; $display("FAIL fwd_phase[%0d]: got %h need %h", k, phase_out, {6'b0, seq[k]});
            end
            checks++;
            if (done !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL fwd_done[%0d]: got %b", k, done);
            end
        end
        @(posedge clk); #1;
        checks++; if (axis_busy !== 4'b0000) begin errors++; $display("FAIL fwd_idle: got %b need 0000", axis_busy); end
        checks++; if (done !== 4'b0000)      begin errors++; $display("FAIL fwd_done_clear: got %b need 0000", done); end
    endtask

    task automatic test_single_rev();
        send(2'd1, 1'b0, 8'd2);
        tick_step();
        checks++; if (phase_out !== 8'h08) begin errors++; $display("FAIL rev_phase1: got %h need 08", phase_out); end
        tick_step();
        checks++; if (phase_out !== 8'h0C) begin errors++; $display("FAIL rev_phase2: got %h need 0c", phase_out); end
        checks++; if (done !== 4'b0010)    begin errors++; $display("FAIL rev_done: got %b need 0010", done); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_ph [4];
        logic [3:0] exp_dn [4];
        int n;
        exp_ph[0] = 8'h01; exp_ph[1] = 8'h11; exp_ph[2] = 8'h13; exp_ph[3] = 8'h33;
        exp_dn[0] = 4'b0000; exp_dn[1] = 4'b0000; exp_dn[2] = 4'b0001; exp_dn[3] = 4'b0100;
        do_reset();
        n = 0;
        while (tick !== 1'b1 && n < 4 * PERIOD) begin @(posedge clk); #1; n++; end
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL rr_align: tick=%b need 1", tick); end
        send(2'd0, 1'b1, 8'd2);
        send(2'd2, 1'b1, 8'd2);
        checks++; if (axis_busy !== 4'b0101) begin errors++; $display("FAIL rr_busy: got %b need 0101", axis_busy); end
        for (int k = 0; k < 4; k++) begin
            tick_step();
            checks++;
            if (phase_out !== exp_ph[k]) begin errors++; $display("FAIL rr_phase[%0d]: got %h need %h", k, phase_out, exp_ph[k]); end
            checks++;
            if (done !== exp_dn[k]) begin errors++; $display("FAIL rr_done[%0d]: got %b need %b", k, done, exp_dn[k]); end
        end
    endtask

    task automatic test_busy_reject();
        logic [1:0] prev;
        int         changes;
        bit         got_done;
        send(2'd3, 1'b1, 8'd3);
        prev      = phase_out[7:6];
        changes   = 0;
        got_done  = 1'b0;
        cmd_axis  = 2'd3;
        cmd_dir   = 1'b1;
        cmd_steps = 8'd7;
        cmd_valid = 1'b1;
        for (int c = 0; c < 10 * PERIOD; c++) begin
            if (c < 2) begin
                checks++;
                if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_ready[%0d]: got %b need 0", c, cmd_ready); end
            end
            if (c == 2) cmd_valid = 1'b0;
            @(posedge clk); #1;
            if (phase_out[7:6] !== prev) changes++;
            prev = phase_out[7:6];
            if (done[3] === 1'b1) begin
                got_done = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        checks++; if (!got_done)               begin errors++; $display("FAIL busy_done: done[3] not seen"); end
        checks++; if (changes != 3)            begin errors++; $display("FAIL busy_steps: got %0d steps need 3", changes); end
        checks++; if (phase_out[7:6] !== 2'b10) begin errors++; $display("FAIL busy_phase: got %b need 10", phase_out[7:6]); end
        // zero-step command completes immediately without going busy
        cmd_axis  = 2'd0;
        cmd_dir   = 1'b1;
        cmd_steps = 8'd0;
        cmd_valid = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b need 1", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++; if (done !== 4'b0001)      begin errors++; $display("FAIL zero_done: got %b need 0001", done); end
        checks++; if (axis_busy !== 4'b0000) begin errors++; $display("FAIL zero_busy: got %b need 0000", axis_busy); end
        @(posedge clk); #1;
        checks++; if (done !== 4'b0000)      begin errors++; $display("FAIL zero_done_clear: got %b need 0000", done); end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        send(2'd2, 1'b1, 8'd5);
        tick_step();
        checks++; if (phase_out !== 8'h10) begin errors++; $display("FAIL mid_phase: got %h need 10", phase_out); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (phase_out !== 8'h00)   begin errors++; $display("FAIL mid_reset_phase: got %h need 00", phase_out); end
        checks++; if (axis_busy !== 4'b0000) begin errors++; $display("FAIL mid_reset_busy: got %b need 0000", axis_busy); end
        reset = 1'b1;
    endtask

`ifdef CONTROLLER_ABORT_EN
    task automatic test_abort();
        do_reset();
        send(2'd2, 1'b1, 8'd5);
        tick_step();
        abort     = 1'b1;
        cmd_axis  = 2'd0;
        cmd_steps = 8'd3;
        cmd_valid = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b need 0", cmd_ready); end
        @(posedge clk); #1;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        checks++; if (axis_busy !== 4'b0000) begin errors++; $display("FAIL abort_busy: got %b need 0000", axis_busy); end
        checks++; if (done !== 4'b0000)      begin errors++; $display("FAIL abort_done: got %b need 0000", done); end
        checks++; if (phase_out !== 8'h10)   begin errors++; $display("FAIL abort_phase: got %h need 10", phase_out); end
        repeat (3 * PERIOD) @(posedge clk);
        #1;
        checks++; if (phase_out !== 8'h10)   begin errors++; $display("FAIL abort_hold: got %h need 10", phase_out); end
    endtask
`endif

    task automatic test_random();
        logic [1:0] ax;
        logic       ab;
        bit         acc;
        bit         found;
        int         a;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            cmd_valid = ($urandom % 2) == 0;
            ax        = 2'($urandom % 4);
            cmd_axis  = ax;
            cmd_dir   = 1'($urandom % 2);
            cmd_steps = CNT_W'($urandom_range(0, 6));
            ab        = 1'b0;
`ifdef CONTROLLER_ABORT_EN
            ab    = ($urandom % 64) == 0;
            abort = ab;
`endif
            #1;
            checks++;
            if (cmd_ready !== ((m_rem[ax] == 0) && !ab)) begin
                errors++; $display("FAIL rnd_ready@%0d: got %b axis %0d", cyc, cmd_ready, ax);
            end
            // advance the model across this clock edge
            acc    = cmd_valid && (m_rem[ax] == 0) && !ab;
            m_done = '0;
            if (ab) begin
                for (int k = 0; k < 4; k++) m_rem[k] = 0;
            end else begin
                if (m_tick) begin
                    found = 1'b0;
                    for (int i = 1; i <= 4; i++) begin
                        a = (m_rr + i) % 4;
                        if (!found && m_rem[a] > 0) begin
                            found    = 1'b1;
                            m_pos[a] = (m_pos[a] + (m_dir[a] ? 1 : 3)) % 4;
                            m_rem[a] = m_rem[a] - 1;
                            if (m_rem[a] == 0) m_done[a] = 1'b1;
                            m_rr     = a;
                        end
                    end
                end
                if (acc) begin
                    m_rem[ax] = int'(cmd_steps);
                    m_dir[ax] = cmd_dir;
                    if (cmd_steps == 0) m_done[ax] = 1'b1;
                end
            end
            m_edges++;
            m_tick = (m_edges % PERIOD) == 0;
            @(posedge clk); #1;
            checks++; if (phase_out !== m_phase()) begin errors++; $display("FAIL rnd_phase@%0d: got %h need %h", cyc, phase_out, m_phase()); end
            checks++; if (axis_busy !== m_busy())  begin errors++; $display("FAIL rnd_busy@%0d: got %b need %b", cyc, axis_busy, m_busy()); end
            checks++; if (done !== m_done)         begin errors++; $display("FAIL rnd_done@%0d: got %b need %b", cyc, done, m_done); end
            checks++; if (tick !== m_tick)         begin errors++; $display("FAIL rnd_tick@%0d: got %b need %b", cyc, tick, m_tick); end
        end
        cmd_valid = 1'b0;
`ifdef CONTROLLER_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    initial begin
        gray_tab[0] = 2'b00;
        gray_tab[1] = 2'b01;
        gray_tab[2] = 2'b11;
        gray_tab[3] = 2'b10;
        test_reset();
        test_single_fwd();
        test_single_rev();
        test_round_robin();
        test_busy_reject();
        test_reset_mid_move();
`ifdef CONTROLLER_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
